bcd_countdown_timer: RTL and testbench

Parametrised BCD minutes:seconds countdown timer for the microwave controller. Keypad digits shift in right-to-left, and start, pause and cancel commands drive a four-state control FSM. An internal prescaler produces the one-second decrement. The block replaces the fixed three-digit loadable counter chain with a single FSM-controlled datapath that has a configurable minutes width and an optional end-of-cook alarm.

---
 rtl/bcd_countdown_timer.sv | 200 ++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module   : bcd_countdown_timer
// Brief    : BCD mm:ss countdown with keypad entry and run/pause/done control.
//            Optional end-of-cook alarm enabled by macro TIMER_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_countdown_timer #(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV   = 50000000,
  parameter int ALARM_SECS = 3
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [3:0]              digit_in,
  input  logic                    digit_valid,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    running,
  output logic                    zero,
  output logic                    done,
  output logic                    alarm
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state, w_next;
  logic [3:0]    r_ones, r_tens;
  logic [MW-1:0] r_mins;
  logic [PW-1:0] r_presc;
  logic [MW-1:0] w_mins_shift;
  logic          w_zero, w_presc_last, w_tick, w_digit_ok;

  function automatic logic [MW-1:0] bcd_dec(input logic [MW-1:0] v);
    logic borrow;
    borrow  = 1'b1;
    bcd_dec = v;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  endfunction

  assign w_zero       = (r_ones == 4'd0) && (r_tens == 4'd0) && (r_mins == '0);
  assign w_presc_last = (r_presc == PW'(TICK_DIV - 1));
  assign w_digit_ok   = digit_valid && (digit_in <= 4'd9);

  // The top minute digit falls off the left end on every keypad shift.
  generate
    if (MIN_DIGITS == 1) begin : g_shift_one
      assign w_mins_shift = r_tens;
    end else begin : g_shift_multi
      assign w_mins_shift = {r_mins[MW-5:0], r_tens};
    end
  endgenerate

`ifdef TIMER_ALARM_EN
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  logic [AW-1:0] r_alarm_cnt;
  logic          w_alarm_end;

  assign w_tick      = ((r_state == S_RUN) || (r_state == S_DONE)) && w_presc_last;
  assign w_alarm_end = w_tick && (r_state == S_DONE) && (r_alarm_cnt == AW'(ALARM_SECS - 1));

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_alarm_cnt <= '0;
    end else if (r_state != S_DONE) begin
      r_alarm_cnt <= '0;
    end else if (w_tick) begin
      r_alarm_cnt <= r_alarm_cnt + 1'b1;
    end
  end
`else
  assign w_tick = (r_state == S_RUN) && w_presc_last;
`endif

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // RUN with all-zero digits is the single done cycle before DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!cancel && !pause && start && !w_zero) w_next = S_RUN;
      end
      S_RUN: begin
        if (cancel)      w_next = S_IDLE;
        else if (w_zero) w_next = S_DONE;
        else if (pause)  w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (cancel)              w_next = S_IDLE;
        else if (!pause && start) w_next = S_RUN;
      end
      S_DONE: begin
`ifdef TIMER_ALARM_EN
        if (cancel || start || w_alarm_end) w_next = S_IDLE;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    running = (r_state == S_RUN);
    zero    = w_zero;
    done    = (r_state == S_RUN) && w_zero;
`ifdef TIMER_ALARM_EN
    alarm   = (r_state == S_DONE);
`else
    alarm   = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_mins  <= '0;
      r_presc <= '0;
    end else if (cancel) begin
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_mins  <= '0;
      r_presc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (!pause && !start && w_digit_ok) begin
            r_mins <= w_mins_shift;
            r_tens <= r_ones;
            r_ones <= digit_in;
          end
        end
        S_RUN: begin
          if (w_zero) begin
            r_presc <= '0;
          end else if (pause) begin
            // A pending tick is held at the last count rather than lost.
            if (!w_presc_last) r_presc <= r_presc + 1'b1;
          end else begin
            r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
            if (w_tick) begin
              if (r_ones != 4'd0) begin
                r_ones <= r_ones - 4'd1;
              end else if (r_tens != 4'd0) begin
                r_tens <= r_tens - 4'd1;
                r_ones <= 4'd9;
              end else if (r_mins != '0) begin
                r_mins <= bcd_dec(r_mins);
                r_tens <= 4'd5;
                r_ones <= 4'd9;
              end
            end
          end
        end
        S_DONE: begin
          r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign sec_ones = r_ones;
  assign sec_tens = r_tens;
  assign mins     = r_mins;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// Module   : tb_bcd_countdown_timer
// Brief    : Directed self-checking bench for bcd_countdown_timer (TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       running, zero, done, alarm;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  bcd_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(4), .ALARM_SECS(3)) dut (
    .clk(clk), .clrn(clrn), .digit_in(digit_in), .digit_valid(digit_valid),
    .start(start), .pause(pause), .cancel(cancel),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .running(running), .zero(zero), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  wire logic [15:0] obs = {running, zero, done, alarm, mins, sec_tens, sec_ones};

  function automatic logic [15:0] ev(input logic r, input logic z, input logic d,
                                     input logic a, input logic [3:0] m,
                                     input logic [3:0] t, input logic [3:0] o);
    return {r, z, d, a, m, t, o};
  endfunction

  task automatic expect_now(input string tag, input logic [15:0] e);
    logic [15:0] want;
    string       name;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    want = exp_q.pop_front();
    name = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    cyc();
    digit_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1; cyc(); cancel = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    clrn = 1'b0;
    cyc();
    expect_now("reset", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));

    // 1: entry and first decrement
    press(4'd1); press(4'd3); press(4'd0);
    expect_now("t1_entry", ev(0, 0, 0, 0, 4'd1, 4'd3, 4'd0));
    do_start();
    expect_now("t1_run", ev(1, 0, 0, 0, 4'd1, 4'd3, 4'd0));
    repeat (3) cyc();
    expect_now("t1_pre_tick", ev(1, 0, 0, 0, 4'd1, 4'd3, 4'd0));
    cyc();
    expect_now("t1_tick", ev(1, 0, 0, 0, 4'd1, 4'd2, 4'd9));
    do_cancel();
    expect_now("t1_cancel", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));

    // 2: minute borrow and tens above 5
    press(4'd1); press(4'd0); press(4'd0);
    do_start();
    repeat (4) cyc();
    expect_now("t2_borrow", ev(1, 0, 0, 0, 4'd0, 4'd5, 4'd9));
    do_cancel();
    press(4'd9); press(4'd0);
    expect_now("t2_entry90", ev(0, 0, 0, 0, 4'd0, 4'd9, 4'd0));
    do_start();
    for (int k = 1; k <= 31; k++) begin
      repeat (4) cyc();
      expect_now("t2_tick", ev(1, 0, 0, 0, 4'd0, 4'((90 - k) / 10), 4'((90 - k) % 10)));
    end
    do_cancel();

    // 3: pause keeps the prescaler
    press(4'd5);
    do_start();
    cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    expect_now("t3_paused", ev(0, 0, 0, 0, 4'd0, 4'd0, 4'd5));
    repeat (10) cyc();
    expect_now("t3_hold", ev(0, 0, 0, 0, 4'd0, 4'd0, 4'd5));
    do_start();
    expect_now("t3_resume", ev(1, 0, 0, 0, 4'd0, 4'd0, 4'd5));
    cyc();
    expect_now("t3_resume1", ev(1, 0, 0, 0, 4'd0, 4'd0, 4'd5));
    cyc();
    expect_now("t3_resume2", ev(1, 0, 0, 0, 4'd0, 4'd0, 4'd4));
    do_cancel();

    // 4: reaching zero
    press(4'd1);
    do_start();
    repeat (3) cyc();
    expect_now("t4_pre", ev(1, 0, 0, 0, 4'd0, 4'd0, 4'd1));
    cyc();
    expect_now("t4_done", ev(1, 1, 1, 0, 4'd0, 4'd0, 4'd0));
`ifdef TIMER_ALARM_EN
    for (int k = 0; k < 12; k++) begin
      cyc();
      expect_now("t4_alarm", ev(0, 1, 0, 1, 4'd0, 4'd0, 4'd0));
    end
    cyc();
    expect_now("t4_alarm_end", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));
    press(4'd7);
    expect_now("t4_idle_digit", ev(0, 0, 0, 0, 4'd0, 4'd0, 4'd7));
`else
    press(4'd7);
    expect_now("t4_done_state", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));
    press(4'd7);
    expect_now("t4_done_ignore", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));
    press(4'd7);
    expect_now("t4_idle_digit", ev(0, 0, 0, 0, 4'd0, 4'd0, 4'd7));
`endif
    do_cancel();

    // 5: edge inputs
    press(4'd5);
    press(4'd12);
    expect_now("t5_bad_digit", ev(0, 0, 0, 0, 4'd0, 4'd0, 4'd5));
    do_cancel();
    do_start();
    repeat (4) cyc();
    expect_now("t5_start_zero", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));
    press(4'd3);
    expect_now("t5_still_idle", ev(0, 0, 0, 0, 4'd0, 4'd0, 4'd3));
    do_start();
    cyc();
    cancel = 1'b1; start = 1'b1;
    cyc();
    cancel = 1'b0; start = 1'b0;
    expect_now("t5_cancel_start", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    expect_now("t5_four_digits", ev(0, 0, 0, 0, 4'd2, 4'd3, 4'd4));
    do_cancel();

    // 6: asynchronous reset mid-run
    press(4'd5); press(4'd3); press(4'd0);
    do_start();
    cyc(); cyc();
    expect_now("t6_running", ev(1, 0, 0, 0, 4'd5, 4'd3, 4'd0));
    #2;
    clrn = 1'b1;
    #1;
    expect_now("t6_async", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));
    cyc();
    clrn = 1'b0;
    cyc();
    expect_now("t6_after", ev(0, 1, 0, 0, 4'd0, 4'd0, 4'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
